bus_write_sequencer: RTL and testbench
======================================

// Module: bus_write_sequencer
// PURPOSE
// - Initiator side of the shared 8-bit register bus. Queues (target, data) write commands, drives them onto the bus, and pulses one active-low load strobe.
// - Every bus register (A, B, OUT, ...) captures the bus on the rising clk edge while its n_load is low. This block is the only bus driver.
// - Sits between the control logic and the register file inside the top-level wrapper.
// PARAMETERS
// - DATA_W      8  bus / data width
// - N_TARGETS   3  number of loadable registers (n_load bits); valid target indices 0..N_TARGETS-1
// - TGT_W       2  cmd_target width; require 2**TGT_W >= N_TARGETS
// - FIFO_DEPTH  4  command FIFO entries, power of 2, >=2
// - SETUP_CYC   1  cycles bus is driven before strobe, >=1
// PORTS
// - clk         in   1                      rising-edge clock, single clock domain
// - rst         in   1                      synchronous, active-high reset
// - cmd_valid   in   1                      command present
// - cmd_ready   out  1                      FIFO can accept; push when cmd_valid&&cmd_ready at posedge
// - cmd_target  in   TGT_W                  destination register index
// - cmd_data    in   DATA_W                 value to write
// - bus         out  DATA_W                 bus data; 0 whenever bus_oe=0
// - bus_oe      out  1                      bus driven by this block
// - n_load      out  N_TARGETS              active-low load strobes, at most one low at a time
// - busy        out  1                      (state!=IDLE) || (fifo_count!=0)
// - fifo_count  out  $clog2(FIFO_DEPTH)+1   queued commands
// - err_target  out  1                      sticky: a command with cmd_target>=N_TARGETS was executed
// - clear_err   in   1                      clears err_target
// BEHAVIOUR
// - Reset: FIFO flushed, count=0. State=IDLE. bus=0, bus_oe=0, n_load=all 1s, err_target=0, busy=0.
// - cmd_ready=0 during rst. Otherwise cmd_ready = (fifo_count<FIFO_DEPTH). A pop in the same cycle does not free a slot.
// - Push and pop in the same cycle: count unchanged. A push when full is ignored, because ready is low.
// - All bus-side outputs are registered.
// - FSM states: IDLE, SETUP, STROBE, and HOLD (HOLD only with the macro).
// - IDLE: if count!=0, pop head into cur_tgt/cur_data; next state SETUP; bus<=cur_data, bus_oe<=1.
// - SETUP: held for SETUP_CYC cycles; n_load all high; bus stable. Then go to STROBE.
// - STROBE: exactly 1 cycle with n_load[cur_tgt]=0, bus still driven.
//   - If cur_tgt>=N_TARGETS: no strobe bit goes low, and err_target is set at the end of STROBE.
// - Leaving STROBE (or HOLD):
//   - If the FIFO is non-empty: pop next and re-enter SETUP directly; bus_oe stays 1.
//   - Otherwise: go to IDLE; bus<=0, bus_oe<=0.
// - Latency (SETUP_CYC=1, FIFO empty, no macro):
//   - Command pushed at edge E0.
//   - Pop at E1; bus/bus_oe valid from E1.
//   - n_load low from E2 to E3; the target captures at E3.
//   - Idle again after E3.
//   - Back-to-back throughput: one write per SETUP_CYC+1 cycles.
// - Commands execute strictly in push order. Data on the bus never changes while any n_load is low.
// - err_target: clear_err clears it; a set in the same cycle wins over clear_err.
// - FIFO pointers wrap modulo FIFO_DEPTH. fifo_count distinguishes full from empty.
// - Reset mid-operation (any state) takes effect on the next edge and overrides all else:
//   - n_load returns to all 1s; queued commands are discarded.
//   - No partial strobe beyond the reset edge.
// CONFIGURATION
// - BUS_HOLD_EN defined: STROBE is followed by 1 HOLD cycle, with bus/bus_oe still driven and n_load all high (hold time after strobe).
//   - Throughput becomes SETUP_CYC+2 cycles per write.
// - BUS_HOLD_EN undefined: no HOLD state; bus is released or changed on the edge that ends STROBE.
// TESTING
// - Single write: tgt=1, data=8'hA5 at E0 -> bus=A5 with oe=1 from E1; n_load=3'b101 for one cycle E2-E3; idle and bus=0 after E3.
// - Burst: push 5 cmds back-to-back (tgt 0,1,2,0,1; data 01..05) -> cmd_ready drops at count=4; strobes occur in order at 2-cycle spacing; bus matches each data.
// - Invalid target: tgt=3, data=8'h3C -> bus cycle runs, n_load stays 3'b111, err_target=1; clear_err -> 0; clear_err on the set cycle -> remains 1.
// - Full + simultaneous push/pop: FIFO full, pop occurs with cmd_valid=1 -> push refused that cycle, count=3, then accepted next cycle.
// - Reset during STROBE: rst=1 while n_load=3'b110 -> next edge n_load=3'b111, bus_oe=0, fifo_count=0, queued cmds never strobed.
// - BUS_HOLD_EN build: single write -> bus still 8'hA5 with oe=1 for one cycle after n_load returns high; burst spacing 3 cycles.

Source files
------------

// File: rtl/bus_write_sequencer.sv
// Register-bus write initiator: queues (target, data) commands and plays each one out as setup + one-cycle active-low load strobe.
// Define BUS_HOLD_EN to add one bus-hold cycle after every strobe.
module bus_write_sequencer #(
  parameter int DATA_W     = 8,
  parameter int N_TARGETS  = 3,
  parameter int TGT_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [TGT_W-1:0]              cmd_target,
  input  logic [DATA_W-1:0]             cmd_data,
  output logic [DATA_W-1:0]             bus,
  output logic                          bus_oe,
  output logic [N_TARGETS-1:0]          n_load,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_target,
  input  logic                          clear_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
`ifdef BUS_HOLD_EN
    , HOLD = 2'd3
`endif
  } state_t;

  state_t                     state_q, state_d;
  logic [TGT_W+DATA_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [TGT_W-1:0]           cur_tgt_q, cur_tgt_d;
  logic [SC_W-1:0]            setup_cnt_q, setup_cnt_d;
  logic [DATA_W-1:0]          bus_q, bus_d;
  logic                       bus_oe_q, bus_oe_d;
  logic [N_TARGETS-1:0]       n_load_q, n_load_d;
  logic                       err_q, err_d;
  logic                       push, pop, leave;
  logic [TGT_W-1:0]           head_tgt;
  logic [DATA_W-1:0]          head_data;
  logic [N_TARGETS-1:0]       tgt_hit;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign cmd_ready  = !rst && (count_q < CNT_W'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign {head_tgt, head_data} = mem[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < N_TARGETS; gi++) begin : g_hit
      assign tgt_hit[gi] = (cur_tgt_q == TGT_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cur_tgt_d   = cur_tgt_q;
    setup_cnt_d = setup_cnt_q;
    bus_d       = bus_q;
    bus_oe_d    = bus_oe_q;
    n_load_d    = '1;
    err_d       = clear_err ? 1'b0 : err_q;
    pop         = 1'b0;
    leave       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      SETUP: begin
        if (setup_cnt_q == SC_W'(SETUP_CYC - 1)) begin
          state_d  = STROBE;
          n_load_d = ~tgt_hit;  // out-of-range target matches no bit
        end else begin
          setup_cnt_d = setup_cnt_q + SC_W'(1);
        end
      end
      STROBE: begin
        if (tgt_hit == '0) err_d = 1'b1;
`ifdef BUS_HOLD_EN
        state_d = HOLD;
`else
        leave = 1'b1;
`endif
      end
`ifdef BUS_HOLD_EN
      HOLD: leave = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
    if (leave) begin
      if (count_q != '0) begin
        pop = 1'b1;
      end else begin
        state_d  = IDLE;
        bus_d    = '0;
        bus_oe_d = 1'b0;
      end
    end
    if (pop) begin
      state_d     = SETUP;
      cur_tgt_d   = head_tgt;
      bus_d       = head_data;
      bus_oe_d    = 1'b1;
      setup_cnt_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cmd_target, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_tgt_q   <= '0;
      setup_cnt_q <= '0;
      bus_q       <= '0;
      bus_oe_q    <= 1'b0;
      n_load_q    <= '1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_tgt_q   <= cur_tgt_d;
      setup_cnt_q <= setup_cnt_d;
      bus_q       <= bus_d;
      bus_oe_q    <= bus_oe_d;
      n_load_q    <= n_load_d;
      err_q       <= err_d;
    end
  end

  assign bus        = bus_q;
  assign bus_oe     = bus_oe_q;
  assign n_load     = n_load_q;
  assign err_target = err_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_bus_write_sequencer.sv
// Bench for bus_write_sequencer: directed scenarios plus random traffic against a
// transaction-timing reference model (queue + pop/strobe schedule).
module tb_bus_write_sequencer;
  localparam int DW = 8;
  localparam int NT = 3;
  localparam int TW = 2;
  localparam int FD = 4;
  localparam int SC = 1;
`ifdef BUS_HOLD_EN
  localparam int HOLD_C = 1;
`else
  localparam int HOLD_C = 0;
`endif
  localparam int P = SC + 1 + HOLD_C;  // cycles per write

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [TW-1:0] cmd_target = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] bus;
  logic          bus_oe;
  logic [NT-1:0] n_load;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          err_target;
  logic          clear_err = 1'b0;

  always #5 clk = ~clk;

  bus_write_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_data(cmd_data), .bus(bus), .bus_oe(bus_oe),
    .n_load(n_load), .busy(busy), .fifo_count(fifo_count),
    .err_target(err_target), .clear_err(clear_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [TW-1:0] tgt; logic [DW-1:0] data; } cmd_t;
  cmd_t mq[$];
  cmd_t act;
  bit   act_v = 0;
  int   act_pop = 0, free_e = 0, e = 0;
  bit   m_err = 0;
  logic [17:0] exp_vec;
  logic [17:0] obs;
  assign obs = {cmd_ready, busy, fifo_count, bus_oe, bus, n_load, err_target};

  // Advance the model over the coming edge using the inputs currently applied.
  task automatic model_step();
    bit push, pop, set, win;
    logic [NT-1:0] nl;
    e++;
    if (rst) begin
      mq.delete();
      act_v  = 0;
      free_e = e;
      m_err  = 0;
    end else begin
      push  = cmd_valid && (mq.size() < FD);
      pop   = (mq.size() > 0) && (e >= free_e);
      set   = act_v && (act.tgt >= NT) && (e == act_pop + SC + 1);
      m_err = set ? 1'b1 : (clear_err ? 1'b0 : m_err);
      if (pop) begin
        act     = mq.pop_front();
        act_v   = 1;
        act_pop = e;
        free_e  = e + P;
      end
      if (push) begin
        cmd_t c;
        c.tgt  = cmd_target;
        c.data = cmd_data;
        mq.push_back(c);
      end
    end
    win = act_v && (e < act_pop + P);
    nl  = '1;
    if (win && (e == act_pop + SC) && (act.tgt < NT)) nl[act.tgt] = 1'b0;
    exp_vec = {!rst && (mq.size() < FD), win || (mq.size() != 0), 3'(mq.size()),
               win, win ? act.data : 8'h00, nl, m_err};
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (obs !== exp_vec) begin errors++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec); end
    checks++;
    if ({n_load, bus_oe, bus, busy, fifo_count, err_target, cmd_ready} !== {3'b111, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state n_load=%b oe=%b bus=%h busy=%b cnt=%0d err=%b ready=%b (want 111 0 00 0 0 0 0)",
               n_load, bus_oe, bus, busy, fifo_count, err_target, cmd_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    cmd_valid = 1'b1; cmd_target = 2'd1; cmd_data = 8'hA5;
    cycle();
    cmd_valid = 1'b0;
    checks++;
    if ({fifo_count, bus_oe} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL single_e0 cnt=%0d oe=%b exp cnt=1 oe=0", fifo_count, bus_oe);
    end
    for (int k = 1; k <= 5; k++) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL single_model k=%0d got=%h exp=%h", k, obs, exp_vec); end
      if (k == 1) begin
        checks++;
        if ({bus, bus_oe, n_load} !== {8'hA5, 1'b1, 3'b111}) begin
          errors++; $display("FAIL single_e1 bus=%h oe=%b nl=%b exp A5 1 111", bus, bus_oe, n_load);
        end
      end
      if (k == 2) begin
        checks++;
        if ({bus, n_load} !== {8'hA5, 3'b101}) begin
          errors++; $display("FAIL single_e2 bus=%h nl=%b exp A5 101", bus, n_load);
        end
      end
      if (k == 3) begin
        checks++;
        if (HOLD_C == 1 && {bus, bus_oe, n_load} !== {8'hA5, 1'b1, 3'b111}) begin
          errors++; $display("FAIL single_hold bus=%h oe=%b nl=%b exp A5 1 111", bus, bus_oe, n_load);
        end
        if (HOLD_C == 0 && {bus, bus_oe, busy} !== {8'h00, 1'b0, 1'b0}) begin
          errors++; $display("FAIL single_e3 bus=%h oe=%b busy=%b exp 00 0 0", bus, bus_oe, busy);
        end
      end
    end
    $display("test_single_write done");
  endtask

  task automatic test_burst();
    logic [TW-1:0] tgts [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    int idx = 0, ns = 0, cyc = 0;
    int s_e [8];
    logic [NT-1:0] s_nl [8];
    logic [DW-1:0] s_bus [8];
    while ((idx < 5 || exp_vec[16]) && cyc < 60) begin
      cmd_valid  = (idx < 5);
      cmd_target = tgts[idx % 5];
      cmd_data   = 8'(idx + 1);
      if (idx < 5 && mq.size() < FD) idx++;
      cycle();
      cyc++;
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL burst_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (n_load !== 3'b111 && ns < 8) begin s_e[ns] = e; s_nl[ns] = n_load; s_bus[ns] = bus; ns++; end
    end
    cmd_valid = 1'b0;
    checks++;
    if (ns !== 5 || cyc >= 60) begin errors++; $display("FAIL burst_count strobes=%0d exp=5 cycles=%0d", ns, cyc); end
    for (int i = 0; i < ns && i < 5; i++) begin
      logic [NT-1:0] want;
      want = '1;
      want[tgts[i]] = 1'b0;
      checks++;
      if ({s_nl[i], s_bus[i]} !== {want, 8'(i + 1)}) begin
        errors++; $display("FAIL burst_order i=%0d nl=%b bus=%h exp nl=%b bus=%h", i, s_nl[i], s_bus[i], want, 8'(i + 1));
      end
      if (i > 0) begin
        checks++;
        if (s_e[i] - s_e[i-1] != P) begin
          errors++; $display("FAIL burst_spacing i=%0d got=%0d exp=%0d", i, s_e[i] - s_e[i-1], P);
        end
      end
    end
    $display("test_burst done strobes=%0d", ns);
  endtask

  task automatic test_full();
    int pushed = 0, cyc = 0, prev_cnt;
    bit saw = 0;
    while ((pushed < 8 || exp_vec[16]) && cyc < 80) begin
      cmd_valid  = (pushed < 8);
      cmd_target = 2'(pushed % 3);
      cmd_data   = 8'h40 + 8'(pushed);
      prev_cnt   = mq.size();
      if (pushed < 8 && mq.size() < FD) pushed++;
      cycle();
      cyc++;
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL full_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (prev_cnt == FD && cmd_valid && !saw && act_pop == e) begin
        saw = 1;
        checks++;
        if ({fifo_count, cmd_ready} !== {3'd3, 1'b1}) begin
          errors++; $display("FAIL full_pushpop cnt=%0d ready=%b exp cnt=3 ready=1", fifo_count, cmd_ready);
        end
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (!saw || cyc >= 80) begin errors++; $display("FAIL full_seen saw=%0d cycles=%0d exp saw=1", saw, cyc); end
    $display("test_full done");
  endtask

  task automatic test_invalid();
    int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      cmd_valid = 1'b1; cmd_target = 2'd3; cmd_data = 8'h3C;
      clear_err = (pass == 1);
      cycle();
      cmd_valid = 1'b0;
      cyc = 0;
      while (exp_vec[16] && cyc < 20) begin
        cycle();
        cyc++;
        checks++;
        if (obs !== exp_vec || n_load !== 3'b111) begin
          errors++; $display("FAIL invalid_run pass=%0d got=%h exp=%h nl=%b", pass, obs, exp_vec, n_load);
        end
      end
      clear_err = 1'b0;
      checks++;
      if (err_target !== 1'b1) begin errors++; $display("FAIL invalid_err pass=%0d got=%b exp=1", pass, err_target); end
      clear_err = 1'b1;
      cycle();
      clear_err = 1'b0;
      checks++;
      if (err_target !== 1'b0 || obs !== exp_vec) begin
        errors++; $display("FAIL invalid_clear pass=%0d err=%b exp=0 got=%h exp=%h", pass, err_target, obs, exp_vec);
      end
    end
    $display("test_invalid done");
  endtask

  task automatic test_reset_strobe();
    bit hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cmd_valid  = (i < 3);
      cmd_target = 2'(i);
      cmd_data   = 8'h11 * 8'(i + 1);
      cycle();
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL rststb_model i=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (n_load === 3'b110) hit = 1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!hit) begin errors++; $display("FAIL rststb_wait strobe 110 never seen"); end
    rst = 1'b1;
    cycle();
    checks++;
    if ({n_load, bus_oe, fifo_count} !== {3'b111, 1'b0, 3'd0}) begin
      errors++; $display("FAIL rststb_state nl=%b oe=%b cnt=%0d exp 111 0 0", n_load, bus_oe, fifo_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec || n_load !== 3'b111) begin
        errors++; $display("FAIL rststb_after i=%0d got=%h exp=%h nl=%b", i, obs, exp_vec, n_load);
      end
    end
    $display("test_reset_strobe done");
  endtask

  task automatic test_random();
    int cyc = 0;
    for (int i = 0; i < 400; i++) begin
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_target = TW'($urandom_range(0, 3));
      cmd_data   = DW'($urandom);
      clear_err  = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 96) == 0);
      cycle();
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_vec); end
    end
    cmd_valid = 1'b0; clear_err = 1'b0; rst = 1'b0;
    while (exp_vec[16] && cyc < 40) begin
      cycle();
      cyc++;
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL random_drain got=%h exp=%h", obs, exp_vec); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL random_idle busy=%b exp=0", busy); end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_full();
    test_invalid();
    test_reset_strobe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
